// File: rtl/id_ex_pipe_pkg.sv
// id_ex_pipe_pkg: shared types, encodings and opcode helpers for the ID/EX pipeline register.
package id_ex_pipe_pkg;
    typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;
    localparam logic [15:0] NOP = 16'h0800;
    localparam logic [4:0] OP_LD  = 5'b10001;
    localparam logic [4:0] OP_ST  = 5'b10000;
    localparam logic [4:0] OP_STU = 5'b10011;
    localparam logic [4:0] OP_ALU = 5'b11011;
    localparam logic [4:0] OP_SEQ = 5'b11100;
    localparam logic [4:0] OP_SLT = 5'b11101;
    localparam logic [4:0] OP_SLE = 5'b11110;
    localparam logic [4:0] OP_SCO = 5'b11111;
    typedef struct packed {
        logic        valid;
        logic [15:0] pc_inc;
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic [15:0] instr;
        logic [1:0]  alusrc;
        logic [3:0]  aluop;
        logic        branch;
        logic        jump;
        logic        inva;
        logic        invb;
        logic        cin;
        logic        memread;
        logic        memwrite;
        logic        regwrite;
        logic [2:0]  writereg;
    } ex_t;
    function automatic ex_t bubble();
        ex_t b;
        b = '0;
        b.instr = NOP;
        return b;
    endfunction
    // R-format ALU ops and stores use bits [7:5] as a source register (Rt)
    function automatic logic reads_rt(input logic [15:0] instr);
        return instr[15:11] inside {OP_ALU, OP_SEQ, OP_SLT, OP_SLE, OP_SCO, OP_ST, OP_STU};
    endfunction
endpackage

// File: rtl/id_ex_pipe_if.sv
// id_ex_pipe_if: decode-side inputs and execute-side outputs of the ID/EX register.
interface id_ex_pipe_if;
    logic        valid_in;
    logic [15:0] PC_Inc_in, Read1data_in, Read2data_in, Instruction_in;
    logic [1:0]  ALUSrc_in;
    logic [3:0]  ALUOp_in;
    logic        Branch_in, Jump_in, InvA_in, InvB_in, Cin_in, MemRead_in, MemWrite_in, RegWrite_in;
    logic [2:0]  WriteReg_in;
    logic        PCSrc_cntrl;
    logic        valid_out;
    logic [15:0] PC_Inc_out, Read1data_out, Read2data_out, Instruction_out;
    logic [1:0]  ALUSrc_out;
    logic [3:0]  ALUOp_out;
    logic        Branch_out, Jump_out, InvA_out, InvB_out, Cin_out, MemRead_out, MemWrite_out, RegWrite_out;
    logic [2:0]  WriteReg_out;
    logic        Load_warning, stall;
    logic [15:0] stall_count;
    modport master (
        output valid_in, PC_Inc_in, Read1data_in, Read2data_in, Instruction_in, ALUSrc_in, ALUOp_in,
               Branch_in, Jump_in, InvA_in, InvB_in, Cin_in, MemRead_in, MemWrite_in, RegWrite_in,
               WriteReg_in, PCSrc_cntrl,
        input  valid_out, PC_Inc_out, Read1data_out, Read2data_out, Instruction_out, ALUSrc_out, ALUOp_out,
               Branch_out, Jump_out, InvA_out, InvB_out, Cin_out, MemRead_out, MemWrite_out, RegWrite_out,
               WriteReg_out, Load_warning, stall, stall_count
    );
    modport slave (
        input  valid_in, PC_Inc_in, Read1data_in, Read2data_in, Instruction_in, ALUSrc_in, ALUOp_in,
               Branch_in, Jump_in, InvA_in, InvB_in, Cin_in, MemRead_in, MemWrite_in, RegWrite_in,
               WriteReg_in, PCSrc_cntrl,
        output valid_out, PC_Inc_out, Read1data_out, Read2data_out, Instruction_out, ALUSrc_out, ALUOp_out,
               Branch_out, Jump_out, InvA_out, InvB_out, Cin_out, MemRead_out, MemWrite_out, RegWrite_out,
               WriteReg_out, Load_warning, stall, stall_count
    );
endinterface

// File: rtl/id_ex_pipe_hazard_detect.sv
// hazard_detect: load-use comparison between the load in execute and the instruction in decode.
module hazard_detect
    import id_ex_pipe_pkg::*;
(
    input  logic        i_valid_ex,
    input  logic        i_memread_ex,
    input  logic [2:0]  i_writereg_ex,
    input  logic        i_valid_id,
    input  logic [15:0] i_instr_id,
    output logic        o_hazard,
    output logic        o_hazard_rs
);
    logic w_load_ex, w_rs_hit, w_rt_hit;
    assign w_load_ex   = i_valid_ex & i_memread_ex & i_valid_id;
    assign w_rs_hit    = i_instr_id[10:8] == i_writereg_ex;
    assign w_rt_hit    = reads_rt(i_instr_id) & (i_instr_id[7:5] == i_writereg_ex);
    assign o_hazard    = w_load_ex & (w_rs_hit | w_rt_hit);
    assign o_hazard_rs = w_load_ex & w_rs_hit;
endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with load-use stall FSM, flush and stall counter.
module id_ex_pipe
    import id_ex_pipe_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    id_ex_pipe_if.slave  bus
);
    ex_t         r_ex;
    state_t      r_state;
    logic        r_fwd_pending, r_load_warning;
    logic [15:0] r_stall_count;
    ex_t         w_in;
    logic        w_hazard, w_hazard_rs, w_stall;
    assign w_in = '{valid: bus.valid_in, pc_inc: bus.PC_Inc_in, rd1: bus.Read1data_in,
                    rd2: bus.Read2data_in, instr: bus.Instruction_in, alusrc: bus.ALUSrc_in,
                    aluop: bus.ALUOp_in, branch: bus.Branch_in, jump: bus.Jump_in,
                    inva: bus.InvA_in, invb: bus.InvB_in, cin: bus.Cin_in,
                    memread: bus.MemRead_in, memwrite: bus.MemWrite_in,
                    regwrite: bus.RegWrite_in, writereg: bus.WriteReg_in};
    hazard_detect u_hazard (
        .i_valid_ex   (r_ex.valid),
        .i_memread_ex (r_ex.memread),
        .i_writereg_ex(r_ex.writereg),
        .i_valid_id   (bus.valid_in),
        .i_instr_id   (bus.Instruction_in),
        .o_hazard     (w_hazard),
        .o_hazard_rs  (w_hazard_rs)
    );
    // A taken branch/jump flushes the dependent instruction, so it must not also stall
    assign w_stall = rst_n & (r_state == RUN) & w_hazard & ~bus.PCSrc_cntrl;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex           <= bubble();
            r_state        <= RUN;
            r_fwd_pending  <= 1'b0;
            r_load_warning <= 1'b0;
            r_stall_count  <= '0;
        end else begin
            r_ex           <= (bus.PCSrc_cntrl | w_stall | ~bus.valid_in) ? bubble() : w_in;
            r_state        <= w_stall ? STALL : RUN;
            r_fwd_pending  <= w_stall & w_hazard_rs;
            r_load_warning <= (r_state == STALL) & r_fwd_pending & bus.valid_in & ~bus.PCSrc_cntrl;
            if (w_stall && r_stall_count != 16'hFFFF)
                r_stall_count <= r_stall_count + 16'd1;
        end
    end
    assign bus.valid_out       = r_ex.valid;
    assign bus.PC_Inc_out      = r_ex.pc_inc;
    assign bus.Read1data_out   = r_ex.rd1;
    assign bus.Read2data_out   = r_ex.rd2;
    assign bus.Instruction_out = r_ex.instr;
    assign bus.ALUSrc_out      = r_ex.alusrc;
    assign bus.ALUOp_out       = r_ex.aluop;
    assign bus.Branch_out      = r_ex.branch;
    assign bus.Jump_out        = r_ex.jump;
    assign bus.InvA_out        = r_ex.inva;
    assign bus.InvB_out        = r_ex.invb;
    assign bus.Cin_out         = r_ex.cin;
    assign bus.MemRead_out     = r_ex.memread;
    assign bus.MemWrite_out    = r_ex.memwrite;
    assign bus.RegWrite_out    = r_ex.regwrite;
    assign bus.WriteReg_out    = r_ex.writereg;
    assign bus.Load_warning    = r_load_warning;
    assign bus.stall           = w_stall;
    assign bus.stall_count     = r_stall_count;
endmodule
